up3down5_decoder: RTL

UP3DOWN5_DECODER -- requirements
Module: up3down5_decoder

---
 rtl/up3down5_pkg.sv | 27 ++
 rtl/up3down5_expect.sv | 23 ++
 rtl/up3down5_decoder.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/up3down5_pkg.sv
// Shared constants, op encoding and state type for the up-3/down-5 counter decoder.
package up3down5_pkg;

    localparam int unsigned CNT_W    = 9;
    localparam int unsigned UP_STEP  = 3;
    localparam int unsigned DN_STEP  = 5;
    localparam int unsigned ERRCNT_W = 8;
    localparam int unsigned OP_W     = 2;

    // Op encoding is {up,down}
    localparam logic [OP_W-1:0] OP_LOAD = 2'b00;
    localparam logic [OP_W-1:0] OP_DOWN = 2'b01;
    localparam logic [OP_W-1:0] OP_UP   = 2'b10;
    localparam logic [OP_W-1:0] OP_HOLD = 2'b11;

    // An up step from prev at or above this value wraps past the top
    localparam logic [CNT_W-1:0] CAR_THRESH = CNT_W'((2 ** CNT_W) - UP_STEP);
    // A down step from prev at or below this value wraps past zero
    localparam logic [CNT_W-1:0] BOR_THRESH = CNT_W'(DN_STEP - 1);

    typedef enum logic [1:0] {
        ST_SYNC  = 2'd0,
        ST_TRACK = 2'd1,
        ST_ERR   = 2'd2
    } state_e;

endpackage

// File: rtl/up3down5_expect.sv
// Expected next counter values, wrap flags and parity for the current sample.
module up3down5_expect
    import up3down5_pkg::*;
(
    input  logic [CNT_W-1:0] prev_i,
    input  logic [CNT_W-1:0] count_i,
    output logic [CNT_W-1:0] up_nxt_c,
    output logic [CNT_W-1:0] dn_nxt_c,
    output logic             ecar_c,
    output logic             ebor_c,
    output logic             exp_par_c
);

    // Modular step targets and the flags a legal step would raise
    always_comb begin
        up_nxt_c  = prev_i + CNT_W'(UP_STEP);
        dn_nxt_c  = prev_i - CNT_W'(DN_STEP);
        ecar_c    = (prev_i >= CAR_THRESH);
        ebor_c    = (prev_i <= BOR_THRESH);
        exp_par_c = ^count_i;
    end

endmodule

// File: rtl/up3down5_decoder.sv
// Decodes observed counter samples into load/down/up/hold ops and flags errors.
module up3down5_decoder
    import up3down5_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic [CNT_W-1:0]    count_in,
    input  logic                parity_in,
    input  logic                carry_in,
    input  logic                borrow_in,
    input  logic                valid_in,
    output logic [OP_W-1:0]     op_out,
    output logic                op_valid,
    output logic                parity_err,
    output logic                seq_err,
    output logic [ERRCNT_W-1:0] err_count,
    output logic                synced
);

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      prev_q, prev_d;
    logic [OP_W-1:0]       op_q, op_d;
    logic                  op_valid_q, op_valid_d;
    logic                  perr_q, perr_d;
    logic                  serr_q, serr_d;
    logic [ERRCNT_W-1:0]   errcnt_q, errcnt_d;
    logic                  synced_q;

    logic [CNT_W-1:0]      up_nxt_c, dn_nxt_c;
    logic                  ecar_c, ebor_c, exp_par_c;
    logic                  par_bad_c;
    logic                  hold_m_c, up_m_c, dn_m_c, load_m_c, any_m_c;

    up3down5_expect u_expect (
        .prev_i    (prev_q),
        .count_i   (count_in),
        .up_nxt_c  (up_nxt_c),
        .dn_nxt_c  (dn_nxt_c),
        .ecar_c    (ecar_c),
        .ebor_c    (ebor_c),
        .exp_par_c (exp_par_c)
    );

    // Candidate-op matches; priority is applied where they are consumed
    assign par_bad_c = (parity_in != exp_par_c);
    assign hold_m_c  = (count_in == prev_q)   && (carry_in == ecar_c) && (borrow_in == ebor_c);
    assign up_m_c    = (count_in == up_nxt_c) && (carry_in == ecar_c) && !borrow_in;
    assign dn_m_c    = (count_in == dn_nxt_c) && (borrow_in == ebor_c) && !carry_in;
    assign load_m_c  = !carry_in && !borrow_in;
    assign any_m_c   = hold_m_c || up_m_c || dn_m_c || load_m_c;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_SYNC;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: SYNC and ERR both resync on the next good-parity sample
    always_comb begin
        state_d = state_q;
        if (valid_in) begin
            if (par_bad_c) begin
                state_d = ST_ERR;
            end else if (state_q == ST_TRACK) begin
                state_d = any_m_c ? ST_TRACK : ST_ERR;
            end else begin
                state_d = ST_TRACK;
            end
        end
    end

    // Output and datapath next values; pulses default low every cycle
    always_comb begin
        prev_d     = prev_q;
        op_d       = op_q;
        op_valid_d = 1'b0;
        perr_d     = 1'b0;
        serr_d     = 1'b0;
        errcnt_d   = errcnt_q;
        if (valid_in) begin
            if (par_bad_c) begin
                perr_d = 1'b1;
            end else begin
                prev_d = count_in;
                if (state_q == ST_TRACK) begin
                    if (hold_m_c) begin
                        op_valid_d = 1'b1;
                        op_d       = OP_HOLD;
                    end else if (up_m_c) begin
                        op_valid_d = 1'b1;
                        op_d       = OP_UP;
                    end else if (dn_m_c) begin
                        op_valid_d = 1'b1;
                        op_d       = OP_DOWN;
                    end else if (load_m_c) begin
                        op_valid_d = 1'b1;
                        op_d       = OP_LOAD;
                    end else begin
                        serr_d = 1'b1;
                    end
                end
            end
        end
        if ((perr_d || serr_d) && (errcnt_q != {ERRCNT_W{1'b1}})) begin
            errcnt_d = errcnt_q + ERRCNT_W'(1);
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_q     <= '0;
            op_q       <= OP_LOAD;
            op_valid_q <= 1'b0;
            perr_q     <= 1'b0;
            serr_q     <= 1'b0;
            errcnt_q   <= '0;
            synced_q   <= 1'b0;
        end else begin
            prev_q     <= prev_d;
            op_q       <= op_d;
            op_valid_q <= op_valid_d;
            perr_q     <= perr_d;
            serr_q     <= serr_d;
            errcnt_q   <= errcnt_d;
            synced_q   <= (state_d == ST_TRACK);
        end
    end

    assign op_out     = op_q;
    assign op_valid   = op_valid_q;
    assign parity_err = perr_q;
    assign seq_err    = serr_q;
    assign err_count  = errcnt_q;
    assign synced     = synced_q;

endmodule
